map_update_arbiter: RTL and testbench

Owns the working copy of the 8x18 card map and the selection bitmap that feed the card display renderer. It arbitrates single-cell writes from two requesters, local input logic and the remote/network side, and sequences a full-board clear. The displayed copy is updated only at the start of vertical blanking, so the renderer never shows a half-updated board.

---
 rtl/map_update_arbiter.sv | 145 ++++++++++++++
 tb/tb_map_update_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_update_arbiter.sv
// Working/display copies of the 8x18 card map and selection bitmap. Arbitrates
// local and remote cell writes, sequences a full-board clear, and commits at vblank.
module map_update_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   v_cnt,
    input  logic         req_loc,
    input  logic [7:0]   loc_pos,
    input  logic [5:0]   loc_card,
    input  logic         loc_sel,
    output logic         loc_ack,
    input  logic         req_rmt,
    input  logic [7:0]   rmt_pos,
    input  logic [5:0]   rmt_card,
    input  logic         rmt_sel,
    output logic         rmt_ack,
    input  logic         clr_req,
    output logic         busy,
    output logic         err_pos,
    output logic         frame_commit,
    output logic [863:0] map,
    output logic [143:0] sel_card
);

    localparam int         CELLS       = 144;
    localparam logic [5:0] EMPTY_CODE  = 6'd54;
    localparam logic [9:0] VBLANK_LINE = 10'd480;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic               rr, rr_nxt;
    logic [9:0]         v_prev;
    logic               commit_pend;
    logic [CELLS*6-1:0] wmap;
    logic [CELLS-1:0]   wsel;

    logic       grant_loc, grant_rmt, grant, pos_ok, clr_wr;
    logic [7:0] grant_pos;
    logic [5:0] grant_card;
    logic       grant_sel;
    logic       wr_en;
    logic [7:0] wr_idx;
    logic [9:0] wr_base;
    logic [5:0] wr_card;
    logic       wr_sel;
    logic       vblank_edge, commit_now;

    assign vblank_edge = (v_cnt == VBLANK_LINE) && (v_prev != VBLANK_LINE);
    // A commit deferred by a clear fires in the first IDLE cycle after it.
    assign commit_now  = (state == IDLE) && (vblank_edge || commit_pend);
    assign busy        = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr;
        grant_loc = 1'b0;
        grant_rmt = 1'b0;
        clr_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 8'd0;
                end else if (req_loc && (!req_rmt || !rr)) begin
                    grant_loc = 1'b1;
                    rr_nxt    = ~rr;
                end else if (req_rmt) begin
                    grant_rmt = 1'b1;
                    rr_nxt    = ~rr;
                end
            end
            CLEAR: begin
                clr_wr  = 1'b1;
                cnt_nxt = cnt + 8'd1;
                if (cnt == 8'(CELLS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant      = grant_loc || grant_rmt;
    assign grant_pos  = grant_rmt ? rmt_pos  : loc_pos;
    assign grant_card = grant_rmt ? rmt_card : loc_card;
    assign grant_sel  = grant_rmt ? rmt_sel  : loc_sel;
    assign pos_ok     = grant_pos < 8'(CELLS);

    // Single write port into the working store, shared by grants and the clear sweep.
    assign wr_en   = (grant && pos_ok) || clr_wr;
    assign wr_idx  = clr_wr ? cnt : grant_pos;
    assign wr_card = clr_wr ? EMPTY_CODE : grant_card;
    assign wr_sel  = clr_wr ? 1'b0 : grant_sel;
    assign wr_base = {2'b00, wr_idx} * 10'd6;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            rr           <= 1'b0;
            v_prev       <= 10'd0;
            commit_pend  <= 1'b0;
            loc_ack      <= 1'b0;
            rmt_ack      <= 1'b0;
            err_pos      <= 1'b0;
            frame_commit <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rr           <= rr_nxt;
            v_prev       <= v_cnt;
            loc_ack      <= grant_loc;
            rmt_ack      <= grant_rmt;
            err_pos      <= grant && !pos_ok;
            frame_commit <= commit_now;
            if (commit_now)
                commit_pend <= 1'b0;
            else if (state == CLEAR && vblank_edge)
                commit_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wmap <= {CELLS{EMPTY_CODE}};
            wsel <= '0;
        end else if (wr_en) begin
            wmap[wr_base +: 6] <= wr_card;
            wsel[wr_idx]       <= wr_sel;
        end
    end

    // Display copy samples the working store before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            map      <= {CELLS{EMPTY_CODE}};
            sel_card <= '0;
        end else if (commit_now) begin
            map      <= wmap;
            sel_card <= wsel;
        end
    end

endmodule

// File: tb/tb_map_update_arbiter.sv
// Bench for map_update_arbiter: directed scenarios plus randomized traffic
// checked against a cell-array model of the working and displayed boards.
module tb_map_update_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   v_cnt;
    logic         req_loc, loc_sel, req_rmt, rmt_sel, clr_req;
    logic [7:0]   loc_pos, rmt_pos;
    logic [5:0]   loc_card, rmt_card;
    logic         loc_ack, rmt_ack, busy, err_pos, frame_commit;
    logic [863:0] map;
    logic [143:0] sel_card;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    map_update_arbiter dut (
        .clk(clk), .rst(rst), .v_cnt(v_cnt),
        .req_loc(req_loc), .loc_pos(loc_pos), .loc_card(loc_card), .loc_sel(loc_sel), .loc_ack(loc_ack),
        .req_rmt(req_rmt), .rmt_pos(rmt_pos), .rmt_card(rmt_card), .rmt_sel(rmt_sel), .rmt_ack(rmt_ack),
        .clr_req(clr_req), .busy(busy), .err_pos(err_pos), .frame_commit(frame_commit),
        .map(map), .sel_card(sel_card)
    );

    // ---------------- reference model: boards as cell arrays ----------------
    logic [5:0] m_wmap[144];
    logic [5:0] m_map[144];
    logic       m_wsel[144];
    logic       m_sel[144];
    logic       m_rr, m_pend;
    int         m_clear_left;
    logic [9:0] m_vprev;
    logic       e_loc_ack, e_rmt_ack, e_err, e_commit, e_busy;

    task automatic model_reset();
        for (int p = 0; p < 144; p++) begin
            m_wmap[p] = 6'd54; m_map[p] = 6'd54; m_wsel[p] = 1'b0; m_sel[p] = 1'b0;
        end
        m_rr = 1'b0; m_pend = 1'b0; m_clear_left = 0; m_vprev = 10'd0;
        e_loc_ack = 1'b0; e_rmt_ack = 1'b0; e_err = 1'b0; e_commit = 1'b0; e_busy = 1'b0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic       edge_now, take_rmt, s;
        logic [7:0] p;
        logic [5:0] c;
        edge_now = (v_cnt == 10'd480) && (m_vprev != 10'd480);
        m_vprev  = v_cnt;
        e_loc_ack = 1'b0; e_rmt_ack = 1'b0; e_err = 1'b0; e_commit = 1'b0;
        if (m_clear_left > 0) begin
            m_wmap[144 - m_clear_left] = 6'd54;
            m_wsel[144 - m_clear_left] = 1'b0;
            m_clear_left--;
            if (edge_now) m_pend = 1'b1;
        end else begin
            if (edge_now || m_pend) begin
                m_map = m_wmap; m_sel = m_wsel; m_pend = 1'b0; e_commit = 1'b1;
            end
            if (clr_req) begin
                m_clear_left = 144;
            end else if (req_loc || req_rmt) begin
                take_rmt = req_rmt && (!req_loc || m_rr);
                p = take_rmt ? rmt_pos : loc_pos;
                c = take_rmt ? rmt_card : loc_card;
                s = take_rmt ? rmt_sel : loc_sel;
                if (p < 8'd144) begin
                    m_wmap[p] = c; m_wsel[p] = s;
                end else begin
                    e_err = 1'b1;
                end
                e_loc_ack = !take_rmt; e_rmt_ack = take_rmt;
                m_rr = !m_rr;
            end
        end
        e_busy = (m_clear_left > 0);
    endtask

    function automatic logic [863:0] model_map_vec();
        logic [863:0] v;
        for (int p = 0; p < 144; p++) v[p*6 +: 6] = m_map[p];
        return v;
    endfunction

    function automatic logic [143:0] model_sel_vec();
        logic [143:0] v;
        for (int p = 0; p < 144; p++) v[p] = m_sel[p];
        return v;
    endfunction

    // ---------------- clock/reset and drivers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (e_loc_ack) req_loc = 1'b0;
        if (e_rmt_ack) req_rmt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_loc = 1'b0; req_rmt = 1'b0; clr_req = 1'b0; v_cnt = 10'd0;
        loc_pos = 8'd0; loc_card = 6'd0; loc_sel = 1'b0;
        rmt_pos = 8'd0; rmt_card = 6'd0; rmt_sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic issue_loc(input logic [7:0] p, input logic [5:0] c, input logic s);
        req_loc = 1'b1; loc_pos = p; loc_card = c; loc_sel = s;
    endtask

    task automatic issue_rmt(input logic [7:0] p, input logic [5:0] c, input logic s);
        req_rmt = 1'b1; rmt_pos = p; rmt_card = c; rmt_sel = s;
    endtask

    task automatic vsync();
        v_cnt = 10'd480;
        tick();
        v_cnt = 10'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [863:0] empty_map;
        empty_map = {144{6'd54}};
        do_reset();
        n_cmp++; if (map !== empty_map) begin n_fail++; $display("FAIL reset_map: got %h want %h", map, empty_map); end
        n_cmp++; if (sel_card !== 144'd0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", sel_card); end
        n_cmp++; if ({loc_ack, rmt_ack, err_pos, frame_commit, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {loc_ack, rmt_ack, err_pos, frame_commit, busy}); end
    endtask

    task automatic test_single_write();
        issue_loc(8'd19, 6'd7, 1'b1);
        tick();
        n_cmp++; if ({loc_ack, rmt_ack, err_pos} !== 3'b100) begin
            n_fail++; $display("FAIL single_ack: got %b want 100", {loc_ack, rmt_ack, err_pos}); end
        repeat (3) tick();
        n_cmp++; if (map[119:114] !== 6'd54) begin n_fail++; $display("FAIL single_precommit: got %0d want 54", map[119:114]); end
        n_cmp++; if (frame_commit !== 1'b0) begin n_fail++; $display("FAIL single_nocommit: got %b want 0", frame_commit); end
        vsync();
        n_cmp++; if (frame_commit !== 1'b1) begin n_fail++; $display("FAIL single_commit: got %b want 1", frame_commit); end
        n_cmp++; if (map[119:114] !== 6'd7 || sel_card[19] !== 1'b1) begin
            n_fail++; $display("FAIL single_cell: got card %0d sel %b want 7 1", map[119:114], sel_card[19]); end
        n_cmp++; if (map !== model_map_vec()) begin n_fail++; $display("FAIL single_map: got %h want %h", map, model_map_vec()); end
        tick();
        n_cmp++; if (frame_commit !== 1'b0) begin n_fail++; $display("FAIL single_once: got %b want 0", frame_commit); end
    endtask

    task automatic test_round_robin();
        // Pointer is 1 after the single local grant; a lone remote grant returns it to 0.
        issue_rmt(8'd30, 6'd1, 1'b0);
        tick();
        n_cmp++; if (rmt_ack !== 1'b1) begin n_fail++; $display("FAIL rr_prep: got %b want 1", rmt_ack); end
        issue_loc(8'd31, 6'd2, 1'b0); issue_rmt(8'd32, 6'd3, 1'b1);
        tick();
        n_cmp++; if ({loc_ack, rmt_ack} !== 2'b10) begin n_fail++; $display("FAIL rr0_first: got %b want 10", {loc_ack, rmt_ack}); end
        tick();
        n_cmp++; if ({loc_ack, rmt_ack} !== 2'b01) begin n_fail++; $display("FAIL rr0_second: got %b want 01", {loc_ack, rmt_ack}); end
        issue_loc(8'd33, 6'd4, 1'b0);
        tick();
        issue_loc(8'd34, 6'd5, 1'b1); issue_rmt(8'd35, 6'd6, 1'b0);
        tick();
        n_cmp++; if ({loc_ack, rmt_ack} !== 2'b01) begin n_fail++; $display("FAIL rr1_first: got %b want 01", {loc_ack, rmt_ack}); end
        tick();
        n_cmp++; if ({loc_ack, rmt_ack} !== 2'b10) begin n_fail++; $display("FAIL rr1_second: got %b want 10", {loc_ack, rmt_ack}); end
    endtask

    task automatic test_out_of_range();
        logic [863:0] before_map;
        logic [143:0] before_sel;
        vsync();
        before_map = model_map_vec();
        before_sel = model_sel_vec();
        issue_rmt(8'd150, 6'd9, 1'b1);
        tick();
        n_cmp++; if ({rmt_ack, err_pos} !== 2'b11) begin n_fail++; $display("FAIL oor_ack: got %b want 11", {rmt_ack, err_pos}); end
        tick();
        n_cmp++; if (err_pos !== 1'b0) begin n_fail++; $display("FAIL oor_pulse: got %b want 0", err_pos); end
        vsync();
        n_cmp++; if (map !== before_map || sel_card !== before_sel) begin
            n_fail++; $display("FAIL oor_board: got %h / %h want %h / %h", map, sel_card, before_map, before_sel); end
    endtask

    task automatic test_clear_fill();
        logic [863:0] want_map;
        int guard, busy_cnt, ack_at;
        logic first_busy;
        for (int k = 0; k < 72; k++) begin
            issue_loc(8'(2*k), 6'd3, 1'b1);
            issue_rmt(8'(2*k+1), 6'd3, 1'b1);
            guard = 0;
            while ((req_loc || req_rmt) && guard < 10) begin tick(); guard++; end
            if (guard >= 10) begin
                n_cmp++; n_fail++; $display("FAIL fill_timeout: pair %0d not granted within 10 cycles", k);
                req_loc = 1'b0; req_rmt = 1'b0;
            end
        end
        vsync();
        want_map = {144{6'd3}};
        n_cmp++; if (map !== want_map || sel_card !== {144{1'b1}}) begin
            n_fail++; $display("FAIL fill_board: got %h / %h want all 3 / all 1", map, sel_card); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0; ack_at = 0; first_busy = busy;
        for (int k = 1; k <= 150; k++) begin
            if (busy) busy_cnt++;
            if (loc_ack && ack_at == 0) ack_at = k;
            if (k == 70) issue_loc(8'd5, 6'd12, 1'b1);
            if (k < 150) tick();
        end
        n_cmp++; if (first_busy !== 1'b1 || busy_cnt != 144) begin
            n_fail++; $display("FAIL clear_busy: got first %b count %0d want 1 144", first_busy, busy_cnt); end
        // Granted in the first IDLE cycle (clr_req + 145), ack one cycle later.
        n_cmp++; if (ack_at != 146) begin n_fail++; $display("FAIL clear_ack_cycle: got %0d want 146", ack_at); end
        vsync();
        want_map = {144{6'd54}};
        want_map[35:30] = 6'd12;
        n_cmp++; if (map !== want_map || sel_card !== (144'd1 << 5)) begin
            n_fail++; $display("FAIL clear_board: got %h / %h want %h / bit5", map, sel_card, want_map); end
    endtask

    task automatic test_vblank_during_clear();
        int bad, commit_at;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bad = 0; commit_at = 0;
        for (int k = 1; k <= 150; k++) begin
            if (frame_commit && busy) bad++;
            if (frame_commit && commit_at == 0) commit_at = k;
            if (k == 30) v_cnt = 10'd480;
            if (k == 31) v_cnt = 10'd0;
            if (k < 150) tick();
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL vclr_overlap: got %0d commits while busy want 0", bad); end
        n_cmp++; if (commit_at != 146) begin n_fail++; $display("FAIL vclr_commit_cycle: got %0d want 146", commit_at); end
        n_cmp++; if (map !== {144{6'd54}} || sel_card !== 144'd0) begin
            n_fail++; $display("FAIL vclr_board: got %h / %h want empty", map, sel_card); end
    endtask

    task automatic test_reset_mid_clear();
        issue_loc(8'd40, 6'd20, 1'b1);
        tick();
        vsync();
        n_cmp++; if (map[245:240] !== 6'd20) begin n_fail++; $display("FAIL rmc_pre: got %0d want 20", map[245:240]); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (69) tick();
        do_reset();
        n_cmp++; if (busy !== 1'b0 || frame_commit !== 1'b0) begin
            n_fail++; $display("FAIL rmc_flags: got busy %b commit %b want 0 0", busy, frame_commit); end
        n_cmp++; if (map !== {144{6'd54}} || sel_card !== 144'd0) begin
            n_fail++; $display("FAIL rmc_board: got %h / %h want empty", map, sel_card); end
        issue_loc(8'd60, 6'd1, 1'b0); issue_rmt(8'd61, 6'd2, 1'b0);
        tick();
        n_cmp++; if ({loc_ack, rmt_ack} !== 2'b10) begin n_fail++; $display("FAIL rmc_rr: got %b want 10", {loc_ack, rmt_ack}); end
        tick();
        issue_loc(8'd19, 6'd7, 1'b1);
        tick();
        n_cmp++; if (loc_ack !== 1'b1) begin n_fail++; $display("FAIL rmc_ack: got %b want 1", loc_ack); end
        vsync();
        n_cmp++; if (map[119:114] !== 6'd7 || sel_card[19] !== 1'b1 || frame_commit !== 1'b1) begin
            n_fail++; $display("FAIL rmc_write: got %0d %b %b want 7 1 1", map[119:114], sel_card[19], frame_commit); end
    endtask

    task automatic test_random();
        int guard;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!req_loc && $urandom_range(0, 2) == 0)
                issue_loc(8'($urandom_range(0, 159)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            if (!req_rmt && $urandom_range(0, 2) == 0)
                issue_rmt(8'($urandom_range(0, 159)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            clr_req = ($urandom_range(0, 249) == 0);
            v_cnt = (cyc % 53 < 2) ? 10'd480 : 10'($urandom_range(0, 479));
            tick();
            n_cmp++; if ({loc_ack, rmt_ack, err_pos, frame_commit, busy} !== {e_loc_ack, e_rmt_ack, e_err, e_commit, e_busy}) begin
                n_fail++; $display("FAIL rand_flags cyc %0d: got %b want %b", cyc,
                    {loc_ack, rmt_ack, err_pos, frame_commit, busy}, {e_loc_ack, e_rmt_ack, e_err, e_commit, e_busy}); end
            if (e_commit) begin
                n_cmp++; if (map !== model_map_vec() || sel_card !== model_sel_vec()) begin
                    n_fail++; $display("FAIL rand_board cyc %0d: got %h want %h", cyc, map, model_map_vec()); end
            end
        end
        clr_req = 1'b0;
        v_cnt = 10'd0;
        guard = 0;
        while ((req_loc || req_rmt || e_busy) && guard < 400) begin tick(); guard++; end
        vsync();
        n_cmp++; if (map !== model_map_vec() || sel_card !== model_sel_vec() || frame_commit !== 1'b1) begin
            n_fail++; $display("FAIL rand_final: got %h commit %b want %h commit 1", map, frame_commit, model_map_vec()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_out_of_range();
        test_clear_fill();
        test_vblank_during_clear();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
